// File: rtl/proc_control_fsm.sv
// proc_control_fsm: multi-cycle control unit for the 16-bit simple processor.
// It captures a 9-bit instruction {III,XXX,YYY} from DIN when Run is seen in T0.
// It then steps through T1..T3, and from the step and the instruction it decodes the
// one-hot bus select, the register/A/G load enables, the ALU add/sub select and Done.
// Optional feature: define CTRL_MVNZ_EN to add opcode 100 (mvnz Rx,Ry, conditional on G_nz).
// Without it, opcode 100 is undefined and is handled like every other undefined opcode.
module proc_control_fsm #(
  parameter int IR_WIDTH    = 9,
  parameter int ILLEGAL_NOP = 1
) (
  input  logic                Clock,
  input  logic                Resetn,
  input  logic                Run,
  input  logic [15:0]         DIN,
  input  logic                G_nz,
  output logic [7:0]          Rin,
  output logic                Ain,
  output logic                Gin,
  output logic                AddSub,
  output logic [9:0]          BusSel,
  output logic                Done,
  output logic [IR_WIDTH-1:0] IR,
  output logic [1:0]          Tstep
);

  // The instruction format is hard-wired to {III,XXX,YYY}; any other width is unusable.
  if (IR_WIDTH != 9) begin : g_bad_ir_width
    $error("proc_control_fsm: IR_WIDTH must be 9");
  end

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MVNZ = 3'b100;

  // Bus select encodings: [9] DIN, [8] R0 .. [1] R7, [0] G.
  localparam logic [9:0] SEL_DIN = 10'b10_0000_0000;
  localparam logic [9:0] SEL_G   = 10'b00_0000_0001;

  state_t        r_state;
  state_t        w_next_state;
  logic [8:0]    r_ir;
  logic [2:0]    w_op;
  logic [2:0]    w_rx;
  logic [2:0]    w_ry;
  logic [7:0]    w_rin;
  logic          w_ain;
  logic          w_gin;
  logic          w_addsub;
  logic [9:0]    w_bussel;
  logic          w_done;
  logic          w_unused;

  // One-hot bus select for general register Ri (R0 sits at bit 8, R7 at bit 1).
  function automatic logic [9:0] sel_reg(input logic [2:0] idx);
    sel_reg = 10'b01_0000_0000 >> idx;
  endfunction

  // One-hot load enable for general register Ri.
  function automatic logic [7:0] rin_dec(input logic [2:0] idx);
    rin_dec = 8'h01 << idx;
  endfunction

  assign w_op = r_ir[8:6];
  assign w_rx = r_ir[5:3];
  assign w_ry = r_ir[2:0];

  // Immediate/data bits below the opcode field never reach the controller.
  // G_nz is only consumed when the mvnz instruction is built in.
  assign w_unused = ^{DIN[6:0], G_nz};

  // State register and instruction capture; reset aborts any instruction in flight.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      r_state <= T0;
      r_ir    <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == T0 && Run) begin
        r_ir <= DIN[15:7];
      end
    end
  end

  // Next-state and output decode from the current step and the captured instruction.
  always_comb begin
    w_next_state = r_state;
    w_rin        = '0;
    w_ain        = 1'b0;
    w_gin        = 1'b0;
    w_addsub     = 1'b0;
    w_bussel     = SEL_DIN;
    w_done       = 1'b0;

    unique case (r_state)
      T0: begin
        // Idle step: enables stay low, DIN is parked on the bus.
        if (Run) begin
          w_next_state = T1;
        end
      end

      T1: begin
        case (w_op)
          OP_MV: begin
            w_bussel     = sel_reg(w_ry);
            w_rin        = rin_dec(w_rx);
            w_done       = 1'b1;
            w_next_state = T0;
          end
          OP_MVI: begin
            // The immediate word is presented on DIN during this step.
            w_bussel     = SEL_DIN;
            w_rin        = rin_dec(w_rx);
            w_done       = 1'b1;
            w_next_state = T0;
          end
          OP_ADD, OP_SUB: begin
            w_bussel     = sel_reg(w_rx);
            w_ain        = 1'b1;
            w_next_state = T2;
          end
`ifdef CTRL_MVNZ_EN
          OP_MVNZ: begin
            // The move still completes when G is zero; only the write is suppressed.
            w_bussel     = sel_reg(w_ry);
            w_rin        = G_nz ? rin_dec(w_rx) : 8'h00;
            w_done       = 1'b1;
            w_next_state = T0;
          end
`endif
          default: begin
            // Undefined opcode: either retire as a NOP or park in T1 until reset.
            w_bussel = SEL_DIN;
            if (ILLEGAL_NOP != 0) begin
              w_done       = 1'b1;
              w_next_state = T0;
            end else begin
              w_next_state = T1;
            end
          end
        endcase
      end

      T2: begin
        // Only add/sub reach this step: second operand into the ALU, sum into G.
        w_bussel     = sel_reg(w_ry);
        w_gin        = 1'b1;
        w_addsub     = (w_op == OP_SUB);
        w_next_state = T3;
      end

      T3: begin
        // Write the ALU result held in G back to Rx.
        w_bussel     = SEL_G;
        w_rin        = rin_dec(w_rx);
        w_done       = 1'b1;
        w_next_state = T0;
      end

      default: begin
        w_next_state = T0;
      end
    endcase
  end

  assign Rin    = w_rin;
  assign Ain    = w_ain;
  assign Gin    = w_gin;
  assign AddSub = w_addsub;
  assign BusSel = w_bussel;
  assign Done   = w_done;
  assign IR     = r_ir;
  assign Tstep  = r_state;

endmodule

// File: tb/tb_proc_control_fsm.sv
// Bench for proc_control_fsm: a table of per-cycle input/expected-output records,
// plus hand-written multi-cycle sequences for latency and throughput.
module tb_proc_control_fsm;

  logic        Clock;
  logic        Resetn;
  logic        Run;
  logic [15:0] DIN;
  logic        G_nz;
  logic [7:0]  Rin;
  logic        Ain;
  logic        Gin;
  logic        AddSub;
  logic [9:0]  BusSel;
  logic        Done;
  logic [8:0]  IR;
  logic [1:0]  Tstep;

  proc_control_fsm dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .Run    (Run),
    .DIN    (DIN),
    .G_nz   (G_nz),
    .Rin    (Rin),
    .Ain    (Ain),
    .Gin    (Gin),
    .AddSub (AddSub),
    .BusSel (BusSel),
    .Done   (Done),
    .IR     (IR),
    .Tstep  (Tstep)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic        rstn;
    logic        run;
    logic [15:0] din;
    logic        gnz;
    logic [1:0]  tstep;
    logic [8:0]  ir;
    logic [9:0]  bus;
    logic [7:0]  rin;
    logic        ain;
    logic        gin;
    logic        addsub;
    logic        done;
  } vec_t;

  vec_t        vecs[$];
  vec_t        exp_q[$];
  int          lat_q[$];
  logic [5:0]  pat_q[$];
  int          n_checks;
  int          n_fails;

  function automatic vec_t mk(input logic rstn, input logic run, input logic [15:0] din,
                              input logic gnz, input logic [1:0] tstep, input logic [8:0] ir,
                              input logic [9:0] bus, input logic [7:0] rin, input logic ain,
                              input logic gin, input logic addsub, input logic done);
    vec_t v;
    v.rstn = rstn; v.run = run; v.din = din; v.gnz = gnz;
    v.tstep = tstep; v.ir = ir; v.bus = bus; v.rin = rin;
    v.ain = ain; v.gin = gin; v.addsub = addsub; v.done = done;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    vec_t e;
    n_checks = 0;
    n_fails  = 0;

    // rstn run din gnz | tstep ir bus rin ain gin addsub done
    vecs.push_back(mk(0,1,16'hFFFF,0, 0,9'h000,10'h200,8'h00,0,0,0,0)); // reset with Run high
    vecs.push_back(mk(0,1,16'hFFFF,0, 0,9'h000,10'h200,8'h00,0,0,0,0));
    vecs.push_back(mk(1,0,16'hFFFF,0, 0,9'h000,10'h200,8'h00,0,0,0,0)); // idle, Run low
    vecs.push_back(mk(1,1,16'h0180,0, 0,9'h000,10'h200,8'h00,0,0,0,0)); // start mv R0,R3
    vecs.push_back(mk(1,0,16'h1234,0, 1,9'h003,10'h020,8'h01,0,0,0,1));
    vecs.push_back(mk(1,1,16'h2C00,0, 0,9'h003,10'h200,8'h00,0,0,0,0)); // start mvi R3
    vecs.push_back(mk(1,1,16'h1234,0, 1,9'h058,10'h200,8'h08,0,0,0,1)); // Run ignored in T1
    vecs.push_back(mk(1,1,16'h4500,0, 0,9'h058,10'h200,8'h00,0,0,0,0)); // start add R1,R2
    vecs.push_back(mk(1,1,16'hFFFF,0, 1,9'h08A,10'h080,8'h00,1,0,0,0));
    vecs.push_back(mk(1,0,16'hFFFF,0, 2,9'h08A,10'h040,8'h00,0,1,0,0));
    vecs.push_back(mk(1,0,16'hFFFF,0, 3,9'h08A,10'h001,8'h02,0,0,0,1));
    vecs.push_back(mk(1,1,16'h6000,0, 0,9'h08A,10'h200,8'h00,0,0,0,0)); // start sub R0,R0
    vecs.push_back(mk(1,0,16'hFFFF,0, 1,9'h0C0,10'h100,8'h00,1,0,0,0));
    vecs.push_back(mk(1,0,16'hFFFF,0, 2,9'h0C0,10'h100,8'h00,0,1,1,0));
    vecs.push_back(mk(1,0,16'hFFFF,0, 3,9'h0C0,10'h001,8'h01,0,0,0,1));
    vecs.push_back(mk(1,0,16'hFFFF,0, 0,9'h0C0,10'h200,8'h00,0,0,0,0)); // Done dropped
    vecs.push_back(mk(1,1,16'hE980,0, 0,9'h0C0,10'h200,8'h00,0,0,0,0)); // start opcode 111
    vecs.push_back(mk(1,0,16'hFFFF,0, 1,9'h1D3,10'h200,8'h00,0,0,0,1));
    vecs.push_back(mk(1,1,16'h9280,0, 0,9'h1D3,10'h200,8'h00,0,0,0,0)); // start opcode 100 R4,R5
`ifdef CTRL_MVNZ_EN
    vecs.push_back(mk(1,0,16'hFFFF,1, 1,9'h125,10'h008,8'h10,0,0,0,1));
`else
    vecs.push_back(mk(1,0,16'hFFFF,1, 1,9'h125,10'h200,8'h00,0,0,0,1));
`endif
    vecs.push_back(mk(1,1,16'h9280,0, 0,9'h125,10'h200,8'h00,0,0,0,0));
`ifdef CTRL_MVNZ_EN
    vecs.push_back(mk(1,0,16'hFFFF,0, 1,9'h125,10'h008,8'h00,0,0,0,1));
`else
    vecs.push_back(mk(1,0,16'hFFFF,0, 1,9'h125,10'h200,8'h00,0,0,0,1));
`endif
    vecs.push_back(mk(1,1,16'h4500,0, 0,9'h125,10'h200,8'h00,0,0,0,0)); // add, aborted in T2
    vecs.push_back(mk(1,0,16'hFFFF,0, 1,9'h08A,10'h080,8'h00,1,0,0,0));
    vecs.push_back(mk(0,0,16'hFFFF,0, 2,9'h08A,10'h040,8'h00,0,1,0,0));
    vecs.push_back(mk(1,0,16'hFFFF,0, 0,9'h000,10'h200,8'h00,0,0,0,0)); // aborted: no write
    vecs.push_back(mk(1,0,16'hFFFF,0, 0,9'h000,10'h200,8'h00,0,0,0,0));

    Resetn = 1'b0;
    Run    = 1'b1;
    DIN    = 16'hFFFF;
    G_nz   = 1'b0;
    repeat (2) @(posedge Clock);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge Clock);
      Resetn = vecs[i].rstn;
      Run    = vecs[i].run;
      DIN    = vecs[i].din;
      G_nz   = vecs[i].gnz;
      exp_q.push_back(vecs[i]);
      #1;
      e = exp_q.pop_front();
      check($sformatf("vec%0d {tstep,ir,bus,rin,ain,gin,addsub,done}", i),
            {31'd0, Tstep, IR, BusSel, Rin, Ain, Gin, AddSub, Done},
            {31'd0, e.tstep, e.ir, e.bus, e.rin, e.ain, e.gin, e.addsub, e.done});
    end

    // add R2,R2: Done on the 3rd cycle after the sampling edge, exactly once, R2 on the bus twice.
    begin
      int first;
      int cnt;
      first = 0;
      cnt   = 0;
      @(negedge Clock);
      Run = 1'b1;
      DIN = 16'h4900;
      lat_q.push_back(3);
      @(posedge Clock);
      #1;
      Run = 1'b0;
      for (int c = 1; c <= 6; c++) begin
        if (c == 1) check("addR2R2 T1 bus", {54'd0, BusSel}, {54'd0, 10'h040});
        if (c == 2) check("addR2R2 T2 bus", {54'd0, BusSel}, {54'd0, 10'h040});
        if (Done === 1'b1) begin
          cnt++;
          if (first == 0) begin
            first = c;
            check("addR2R2 write Rin", {56'd0, Rin}, {56'd0, 8'h04});
          end
        end
        @(posedge Clock);
        #1;
      end
      check("addR2R2 done latency", 64'(first), 64'(lat_q.pop_front()));
      check("addR2R2 done pulses", 64'(cnt), 64'd1);
    end

    // mv R7,R6 with Run held high: a new start every 2 cycles, Done in cycles 1,3,5.
    begin
      logic [5:0] pat;
      pat = '0;
      @(negedge Clock);
      Run = 1'b1;
      DIN = 16'h1F00;
      pat_q.push_back(6'b010101);
      @(posedge Clock);
      #1;
      for (int c = 1; c <= 6; c++) begin
        pat[c-1] = (Done === 1'b1);
        if (c == 1) check("mvR7R6 bus/rin", {46'd0, BusSel, Rin}, {46'd0, 10'h004, 8'h80});
        @(posedge Clock);
        #1;
      end
      Run = 1'b0;
      check("mv throughput done pattern", {58'd0, pat}, {58'd0, pat_q.pop_front()});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Absolute time limit so the run always ends with a summary.
  initial begin
    #100000;
    n_fails++;
    $display("FAIL timeout: got no completion, expected end of stimulus");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
